// File: rtl/cp0_exp_arbiter_pkg.sv
// Shared types for the CP0 exception-entry arbiter.
package cp0_exp_arbiter_pkg;

    localparam int unsigned CP0_NSRC = 3;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        GAP
    } exp_arb_state_t;

endpackage

// File: rtl/cp0_exp_arbiter_if.sv
// Source/CP0 side bundle of the exception-entry arbiter.
import cp0_exp_arbiter_pkg::*;

interface cp0_exp_arbiter_if #(
    parameter int unsigned NSRC = CP0_NSRC
);
    localparam int unsigned CW = (NSRC > 1) ? $clog2(NSRC) : 1;

    logic [NSRC-1:0] irq_in;
    logic            mask_we;
    logic [NSRC-1:0] mask_wdata;
    logic [NSRC-1:0] mask_rdata;
    logic            exp_block;
    logic [NSRC-1:0] exp_req;
    logic [CW-1:0]   exp_code;
    logic            exp_taken;
    logic            eret;
    logic [NSRC-1:0] pending;
    logic [NSRC-1:0] in_service;

    modport master (
        output irq_in, mask_we, mask_wdata, exp_block, exp_taken, eret,
        input  mask_rdata, exp_req, exp_code, pending, in_service
    );

    modport slave (
        input  irq_in, mask_we, mask_wdata, exp_block, exp_taken, eret,
        output mask_rdata, exp_req, exp_code, pending, in_service
    );

endinterface

// File: rtl/cp0_exp_arbiter_prio_enc.sv
// Lowest-set-bit priority encoder: one-hot, index and valid.
module cp0_exp_arbiter_prio_enc #(
    parameter int unsigned WIDTH = 3,
    localparam int unsigned IW   = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] vec,
    output logic [WIDTH-1:0] onehot,
    output logic [IW-1:0]    idx,
    output logic             valid
);

    // Scan from the top so the lowest set bit is the last one written.
    always_comb begin
        onehot = '0;
        idx    = '0;
        valid  = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec[i]) begin
                onehot    = '0;
                onehot[i] = 1'b1;
                idx       = IW'(i);
                valid     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cp0_exp_arbiter.sv
// Fixed-priority CP0 exception-entry arbiter with nesting and ERET retirement.
import cp0_exp_arbiter_pkg::*;

module cp0_exp_arbiter #(
    parameter int unsigned     NSRC     = CP0_NSRC,
    parameter logic [NSRC-1:0] EDGE_SRC = '1,
    parameter bit              NEST     = 1'b1,
    parameter logic [NSRC-1:0] MASK_RST = '0
) (
    input logic              clk,
    input logic              reset,
    cp0_exp_arbiter_if.slave bus
);

    localparam int unsigned CW = (NSRC > 1) ? $clog2(NSRC) : 1;

    exp_arb_state_t  state_q, state_d;
    logic [NSRC-1:0] mask_q, pending_q, in_service_q, irq_prev_q, exp_req_q;
    logic [NSRC-1:0] exp_req_d;
    logic [CW-1:0]   exp_code_q, exp_code_d;

    logic [NSRC-1:0] set_vec, above, elig;
    logic [NSRC-1:0] win_oh, ret_oh;
    logic [CW-1:0]   win_idx, ret_idx_unused;
    logic            win_valid, ret_valid;
    logic            seen, take, hold;

    assign set_vec = (EDGE_SRC & bus.irq_in & ~irq_prev_q) | (~EDGE_SRC & bus.irq_in);

    // A source is eligible only if nothing of equal or higher priority is in service.
    always_comb begin
        above = '0;
        seen  = 1'b0;
        if (NEST) begin
            for (int i = 0; i < int'(NSRC); i++) begin
                seen     = seen | in_service_q[i];
                above[i] = ~seen;
            end
        end else begin
            above = (in_service_q == '0) ? '1 : '0;
        end
    end

    assign elig = pending_q & ~mask_q & above;
    assign hold = |(elig & exp_req_q);

    cp0_exp_arbiter_prio_enc #(.WIDTH(NSRC)) u_win_enc (
        .vec    (elig),
        .onehot (win_oh),
        .idx    (win_idx),
        .valid  (win_valid)
    );

    cp0_exp_arbiter_prio_enc #(.WIDTH(NSRC)) u_ret_enc (
        .vec    (in_service_q),
        .onehot (ret_oh),
        .idx    (ret_idx_unused),
        .valid  (ret_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (win_valid && !bus.exp_block) state_d = REQ;
            REQ: begin
                if (bus.exp_taken)                 state_d = GAP;
                else if (bus.exp_block || !hold)   state_d = IDLE;
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        exp_req_d  = '0;
        exp_code_d = exp_code_q;
        take       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (win_valid && !bus.exp_block) begin
                    exp_req_d  = win_oh;
                    exp_code_d = win_idx;
                end
            end
            REQ: begin
                if (bus.exp_taken)                   take      = 1'b1;
                else if (!bus.exp_block && hold)     exp_req_d = exp_req_q;
            end
            default: ;
        endcase
    end

    // New captures win over the clear of the source being taken.
    always_ff @(posedge clk) begin
        if (reset) begin
            mask_q       <= MASK_RST;
            pending_q    <= '0;
            in_service_q <= '0;
            irq_prev_q   <= '0;
            exp_req_q    <= '0;
            exp_code_q   <= '0;
        end else begin
            if (bus.mask_we) mask_q <= bus.mask_wdata;
            pending_q    <= (pending_q & ~(take ? exp_req_q : '0)) | set_vec;
            in_service_q <= (in_service_q & ~((bus.eret && ret_valid) ? ret_oh : '0))
                            | (take ? exp_req_q : '0);
            irq_prev_q   <= bus.irq_in;
            exp_req_q    <= exp_req_d;
            exp_code_q   <= exp_code_d;
        end
    end

    assign bus.mask_rdata = mask_q;
    assign bus.pending    = pending_q;
    assign bus.in_service = in_service_q;
    assign bus.exp_req    = exp_req_q;
    assign bus.exp_code   = exp_code_q;

endmodule

// File: tb/tb_cp0_exp_arbiter.sv
// Directed bench: nesting DUT plus a non-nesting DUT sharing the same stimulus.
module tb_cp0_exp_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] irq_in, mask_wdata;
    logic       mask_we, exp_block, exp_taken, eret;
    int         checks = 0;
    int         failures = 0;

    cp0_exp_arbiter_if #(.NSRC(3)) bus ();
    cp0_exp_arbiter_if #(.NSRC(3)) bus_n ();

    assign bus.irq_in       = irq_in;
    assign bus.mask_we      = mask_we;
    assign bus.mask_wdata   = mask_wdata;
    assign bus.exp_block    = exp_block;
    assign bus.exp_taken    = exp_taken;
    assign bus.eret         = eret;
    assign bus_n.irq_in     = irq_in;
    assign bus_n.mask_we    = mask_we;
    assign bus_n.mask_wdata = mask_wdata;
    assign bus_n.exp_block  = exp_block;
    assign bus_n.exp_taken  = exp_taken;
    assign bus_n.eret       = eret;

    cp0_exp_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    cp0_exp_arbiter #(.NEST(1'b0)) dut_n (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_n)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; irq_in = '0; mask_we = 1'b0; mask_wdata = '0;
        exp_block = 1'b0; exp_taken = 1'b0; eret = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();
        chk("rst_req", 8'(bus.exp_req), 8'h0);
        chk("rst_pend", 8'(bus.pending), 8'h0);
        chk("rst_isv", 8'(bus.in_service), 8'h0);
        chk("rst_mask", 8'(bus.mask_rdata), 8'h0);
        chk("rst_code", 8'(bus.exp_code), 8'h0);

        // 1: single edge on source 1
        irq_in = 3'b010; tick(); irq_in = '0;
        chk("t1_pend", 8'(bus.pending), 8'h2);
        chk("t1_req_early", 8'(bus.exp_req), 8'h0);
        tick();
        chk("t1_req", 8'(bus.exp_req), 8'h2);
        chk("t1_code", 8'(bus.exp_code), 8'h1);
        exp_taken = 1'b1; tick(); exp_taken = 1'b0;
        chk("t1_isv", 8'(bus.in_service), 8'h2);
        chk("t1_pend_clr", 8'(bus.pending), 8'h0);
        chk("t1_req_off", 8'(bus.exp_req), 8'h0);
        tick();
        chk("t1_gap", 8'(bus.exp_req), 8'h0);
        eret = 1'b1; tick(); eret = 1'b0;
        chk("t1_eret", 8'(bus.in_service), 8'h0);

        // 2: simultaneous edges on 1 and 2
        irq_in = 3'b110; tick(); irq_in = '0;
        chk("t2_pend", 8'(bus.pending), 8'h6);
        tick();
        chk("t2_req1", 8'(bus.exp_req), 8'h2);
        exp_taken = 1'b1; tick(); exp_taken = 1'b0;
        chk("t2_pend_left", 8'(bus.pending), 8'h4);
        tick();
        chk("t2_blocked", 8'(bus.exp_req), 8'h0);
        eret = 1'b1; tick(); eret = 1'b0;
        chk("t2_eret", 8'(bus.in_service), 8'h0);
        tick();
        chk("t2_req2", 8'(bus.exp_req), 8'h4);
        chk("t2_code2", 8'(bus.exp_code), 8'h2);
        exp_taken = 1'b1; tick(); exp_taken = 1'b0;
        tick();
        chk("t3_isv_pre", 8'(bus.in_service), 8'h4);
        chk("t3_n_isv_pre", 8'(bus_n.in_service), 8'h4);

        // 3: preemption with nesting, none without
        irq_in = 3'b001; tick(); irq_in = '0;
        tick();
        chk("t3_req0", 8'(bus.exp_req), 8'h1);
        chk("t3_code0", 8'(bus.exp_code), 8'h0);
        chk("t3_n_noreq", 8'(bus_n.exp_req), 8'h0);
        exp_taken = 1'b1; tick(); exp_taken = 1'b0;
        chk("t3_isv101", 8'(bus.in_service), 8'h5);
        chk("t3_n_isv", 8'(bus_n.in_service), 8'h4);
        chk("t3_n_pend", 8'(bus_n.pending), 8'h1);
        eret = 1'b1; tick(); eret = 1'b0;
        chk("t3_eret1", 8'(bus.in_service), 8'h4);
        chk("t3_n_eret", 8'(bus_n.in_service), 8'h0);
        tick();
        chk("t3_n_req", 8'(bus_n.exp_req), 8'h1);
        chk("t3_hold_isv", 8'(bus.in_service), 8'h4);
        eret = 1'b1; tick(); eret = 1'b0;
        chk("t3_eret2", 8'(bus.in_service), 8'h0);
        exp_taken = 1'b1; tick(); exp_taken = 1'b0;
        chk("t3_n_take", 8'(bus_n.in_service), 8'h1);
        eret = 1'b1; tick(); eret = 1'b0;
        chk("t3_n_clean", 8'(bus_n.in_service), 8'h0);

        // 4: mask gates selection but keeps pending
        mask_we = 1'b1; mask_wdata = 3'b010; tick(); mask_we = 1'b0;
        chk("t4_mask", 8'(bus.mask_rdata), 8'h2);
        irq_in = 3'b010; tick(); irq_in = '0;
        chk("t4_pend", 8'(bus.pending), 8'h2);
        tick(); tick();
        chk("t4_masked", 8'(bus.exp_req), 8'h0);
        mask_we = 1'b1; mask_wdata = 3'b000; tick(); mask_we = 1'b0;
        chk("t4_not_yet", 8'(bus.exp_req), 8'h0);
        tick();
        chk("t4_req", 8'(bus.exp_req), 8'h2);
        exp_taken = 1'b1; tick(); exp_taken = 1'b0;
        tick();
        eret = 1'b1; tick(); eret = 1'b0;
        chk("t4_clean", 8'(bus.in_service), 8'h0);

        // 5: exp_block retracts and later re-issues
        irq_in = 3'b100; tick(); irq_in = '0;
        tick();
        chk("t5_req", 8'(bus.exp_req), 8'h4);
        exp_block = 1'b1; tick();
        chk("t5_retract", 8'(bus.exp_req), 8'h0);
        chk("t5_pend_kept", 8'(bus.pending), 8'h4);
        tick();
        chk("t5_still_blk", 8'(bus.exp_req), 8'h0);
        exp_block = 1'b0; tick();
        chk("t5_reissue", 8'(bus.exp_req), 8'h4);

        // 6: eret and exp_taken together, then reset during REQ
        exp_taken = 1'b1; tick(); exp_taken = 1'b0;
        chk("t6_isv100", 8'(bus.in_service), 8'h4);
        tick();
        irq_in = 3'b001; tick(); irq_in = '0;
        tick();
        chk("t6_req0", 8'(bus.exp_req), 8'h1);
        exp_taken = 1'b1; eret = 1'b1; tick(); exp_taken = 1'b0; eret = 1'b0;
        chk("t6_isv001", 8'(bus.in_service), 8'h1);
        tick();
        eret = 1'b1; tick(); eret = 1'b0;
        chk("t6_isv_clr", 8'(bus.in_service), 8'h0);
        mask_we = 1'b1; mask_wdata = 3'b101; tick(); mask_we = 1'b0;
        irq_in = 3'b010; tick(); irq_in = '0;
        tick();
        chk("t6_req1", 8'(bus.exp_req), 8'h2);
        reset = 1'b1; tick();
        chk("t6_rst_req", 8'(bus.exp_req), 8'h0);
        chk("t6_rst_pend", 8'(bus.pending), 8'h0);
        chk("t6_rst_isv", 8'(bus.in_service), 8'h0);
        chk("t6_rst_mask", 8'(bus.mask_rdata), 8'h0);
        chk("t6_rst_code", 8'(bus.exp_code), 8'h0);
        reset = 1'b0; tick();
        chk("t6_post_rst", 8'(bus.exp_req), 8'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
